psram_port_arbiter: RTL and testbench

PSRAM_PORT_ARBITER -- requirements
Module: psram_port_arbiter

---
 rtl/psram_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_psram_port_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-command PSRAM controller.
// Serialises one operation at a time: grant, strobe, wait for busy to rise and fall, ack.
module psram_port_arbiter #(
    parameter int unsigned ADDR_W = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_wr,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [15:0]       p0_din,
    input  logic              p0_byte,
    output logic              p0_ack,
    input  logic              p1_req,
    input  logic              p1_wr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [15:0]       p1_din,
    input  logic              p1_byte,
    output logic              p1_ack,
    output logic [15:0]       rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic              mem_byte,
    input  logic              mem_busy,
    input  logic [15:0]       mem_dout
);

    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                last_q, last_d;
    logic                gnt_q, gnt_d;
    logic                wr_q, wr_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_din_q, mem_din_d;
    logic                mem_byte_q, mem_byte_d;
    logic                p0_ack_q, p0_ack_d;
    logic                p1_ack_q, p1_ack_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                sel;
    logic                sel_wr;

    // Next-state and output logic; a pending ack blocks a grant so a stale req is never re-served
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        wr_d        = wr_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_byte_d  = mem_byte_q;
        p0_ack_d    = 1'b0;
        p1_ack_d    = 1'b0;
        rdata_d     = rdata_q;
        sel         = (p0_req && p1_req) ? ~last_q : p1_req;
        sel_wr      = sel ? p1_wr : p0_wr;

        unique case (state_q)
            IDLE: begin
                if (!mem_busy && !p0_ack_q && !p1_ack_q && (p0_req || p1_req)) begin
                    gnt_d       = sel;
                    last_d      = sel;
                    wr_d        = sel_wr;
                    mem_addr_d  = sel ? p1_addr : p0_addr;
                    mem_din_d   = sel ? p1_din : p0_din;
                    mem_byte_d  = sel ? p1_byte : p0_byte;
                    mem_read_d  = ~sel_wr;
                    mem_write_d = sel_wr;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (mem_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!mem_busy) begin
                    p0_ack_d = ~gnt_q;
                    p1_ack_d = gnt_q;
                    if (!wr_q) begin
                        rdata_d = mem_dout;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; last-grant resets to port 1 so port 0 wins first contention
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            wr_q        <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_byte_q  <= 1'b0;
            p0_ack_q    <= 1'b0;
            p1_ack_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            wr_q        <= wr_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_byte_q  <= mem_byte_d;
            p0_ack_q    <= p0_ack_d;
            p1_ack_q    <= p1_ack_d;
            rdata_q     <= rdata_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign mem_byte  = mem_byte_q;
    assign p0_ack    = p0_ack_q;
    assign p1_ack    = p1_ack_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_psram_port_arbiter.sv
// Bench for psram_port_arbiter: queued port drivers, a behavioural PSRAM controller,
// and a memory/ordering reference model checked at every ack.
module tb_psram_port_arbiter;

    localparam int unsigned ADDR_W = 22;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       din;
        logic              byt;
    } op_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              p0_req = 1'b0, p0_wr = 1'b0, p0_byte = 1'b0, p0_ack;
    logic [ADDR_W-1:0] p0_addr = '0;
    logic [15:0]       p0_din = '0;
    logic              p1_req = 1'b0, p1_wr = 1'b0, p1_byte = 1'b0, p1_ack;
    logic [ADDR_W-1:0] p1_addr = '0;
    logic [15:0]       p1_din = '0;
    logic [15:0]       rdata;
    logic              mem_read, mem_write, mem_byte, mem_busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_din;
    logic [15:0]       mem_dout = '0;

    psram_port_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_din(p0_din),
        .p0_byte(p0_byte), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_din(p1_din),
        .p1_byte(p1_byte), .p1_ack(p1_ack),
        .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_byte(mem_byte),
        .mem_busy(mem_busy), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int widx(logic [ADDR_W-1:0] a);
        return int'(a[7:1]);
    endfunction

    // Byte writes: addr[0]=1 updates the upper lane from din[15:8], else the lower lane from din[7:0]
    function automatic logic [15:0] merge(logic [15:0] old, op_t op);
        if (!op.byt) return op.din;
        return op.addr[0] ? {op.din[15:8], old[7:0]} : {old[15:8], op.din[7:0]};
    endfunction

    function automatic op_t mk_op(logic wr, logic [ADDR_W-1:0] addr, logic [15:0] din, logic byt);
        op_t o;
        o.wr = wr; o.addr = addr; o.din = din; o.byt = byt;
        return o;
    endfunction

    function automatic op_t rand_op();
        return mk_op(1'($urandom_range(0, 1)), ADDR_W'($urandom), 16'($urandom),
                     1'($urandom_range(0, 1)));
    endfunction

    // Behavioural controller: busy rises ctl_delay+1 cycles after the strobe, lasts ctl_len cycles
    int unsigned ctl_delay = 0, ctl_len = 3;
    int unsigned ctl_phase = 0, ctl_cnt = 0;
    logic        force_busy;
    logic        ctl_busy = 1'b0;
    op_t         cap_op = '0;
    logic [15:0] env_mem [128] = '{default: '0};

    assign mem_busy = force_busy | ctl_busy;

    always @(posedge clk) begin
        if (mem_read || mem_write) begin
            cap_op    <= {mem_write, mem_addr, mem_din, mem_byte};
            ctl_phase <= 1;
            ctl_cnt   <= ctl_delay;
        end else if (ctl_phase == 1) begin
            if (ctl_cnt == 0) begin
                ctl_busy  <= 1'b1;
                ctl_phase <= 2;
                ctl_cnt   <= ctl_len - 1;
            end else begin
                ctl_cnt <= ctl_cnt - 1;
            end
        end else if (ctl_phase == 2) begin
            if (ctl_cnt == 0) begin
                ctl_busy  <= 1'b0;
                ctl_phase <= 0;
                if (cap_op.wr) begin
                    env_mem[widx(cap_op.addr)] <= merge(env_mem[widx(cap_op.addr)], cap_op);
                    mem_dout <= ~cap_op.din;
                end else begin
                    mem_dout <= env_mem[widx(cap_op.addr)];
                end
            end else begin
                ctl_cnt <= ctl_cnt - 1;
            end
        end
    end

    // Port drivers: hold req and fields until ack, chain the next queued op back-to-back
    op_t q0[$], q1[$];
    op_t cur0 = '0, cur1 = '0;

    always @(posedge clk) begin
        if (reset) begin
            p0_req <= 1'b0;
        end else if (!p0_req || p0_ack) begin
            if (q0.size() != 0) begin
                {p0_wr, p0_addr, p0_din, p0_byte} <= q0[0];
                cur0   <= q0[0];
                q0.delete(0);
                p0_req <= 1'b1;
            end else begin
                p0_req <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            p1_req <= 1'b0;
        end else if (!p1_req || p1_ack) begin
            if (q1.size() != 0) begin
                {p1_wr, p1_addr, p1_din, p1_byte} <= q1[0];
                cur1   <= q1[0];
                q1.delete(0);
                p1_req <= 1'b1;
            end else begin
                p1_req <= 1'b0;
            end
        end
    end

    // Monitor and reference model, sampled on the falling edge
    int          cyc = 0, rise_cyc = 0, fall_cyc = 0, strobe_cyc = 0;
    int          strobes_open = 0, nstrobe = 0, nack0 = 0, nack1 = 0;
    logic        busy_prev = 1'b0, stable_ok = 1'b1, ack_port;
    logic [15:0] exp_rdata = '0;
    logic [15:0] ref_mem [128];
    op_t         flight = '0, exp_op;
    int          order[$];

    initial begin
        for (int i = 0; i < 128; i++) ref_mem[i] = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mem_busy && !busy_prev) rise_cyc = cyc;
            if (!mem_busy && busy_prev) fall_cyc = cyc;
            busy_prev = mem_busy;
            if (reset) begin
                strobes_open = 0;
                exp_rdata    = '0;
            end else begin
                if (mem_read || mem_write) begin
                    nstrobe++;
                    strobes_open++;
                    strobe_cyc = cyc;
                    flight     = {mem_write, mem_addr, mem_din, mem_byte};
                    stable_ok  = 1'b1;
                end else if ({mem_addr, mem_din, mem_byte} != {flight.addr, flight.din, flight.byt}) begin
                    stable_ok = 1'b0;
                end
                if (p0_ack || p1_ack) begin
                    chk("one_ack", 64'(p0_ack & p1_ack), 64'd0);
                    ack_port = p1_ack;
                    exp_op   = ack_port ? cur1 : cur0;
                    chk("op_route", 64'(flight), 64'(exp_op));
                    chk("one_strobe", 64'(strobes_open), 64'd1);
                    chk("busy_seq", 64'(rise_cyc > strobe_cyc && fall_cyc > rise_cyc && cyc > fall_cyc), 64'd1);
                    chk("fields_stable", 64'(stable_ok), 64'd1);
                    if (exp_op.wr) begin
                        ref_mem[widx(exp_op.addr)] = merge(ref_mem[widx(exp_op.addr)], exp_op);
                        chk("rdata_hold", 64'(rdata), 64'(exp_rdata));
                    end else begin
                        exp_rdata = ref_mem[widx(exp_op.addr)];
                        chk("rdata", 64'(rdata), 64'(exp_rdata));
                    end
                    order.push_back(int'(ack_port));
                    if (ack_port) nack1++; else nack0++;
                    strobes_open = 0;
                end
            end
        end
    end

    task automatic wait_acks(string tag, int target, int budget);
        int i = 0;
        while ((nack0 + nack1) < target && i < budget) begin
            @(negedge clk); #1;
            i++;
        end
        chk(tag, 64'((nack0 + nack1) >= target), 64'd1);
    endtask

    task automatic chk_reset_outs(string tag);
        chk({tag, "_read"},  64'(mem_read),  64'd0);
        chk({tag, "_write"}, 64'(mem_write), 64'd0);
        chk({tag, "_addr"},  64'(mem_addr),  64'd0);
        chk({tag, "_din"},   64'(mem_din),   64'd0);
        chk({tag, "_byte"},  64'(mem_byte),  64'd0);
        chk({tag, "_ack0"},  64'(p0_ack),    64'd0);
        chk({tag, "_ack1"},  64'(p1_ack),    64'd0);
        chk({tag, "_rdata"}, 64'(rdata),     64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, base, n;
        reset = 1'b1;
        force_busy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk_reset_outs("rst");
        reset = 1'b0;

        // Init hold: busy for 200 cycles, then the strobe is sampled on the second edge after busy falls
        q0.push_back(mk_op(1'b0, ADDR_W'(32'h40), 16'h0, 1'b0));
        repeat (200) begin @(negedge clk); #1; end
        chk("init_no_strobe", 64'(nstrobe), 64'd0);
        force_busy = 1'b0;
        got = 0;
        for (int k = 1; k <= 6 && got == 0; k++) begin
            @(negedge clk); #1;
            if (mem_read) got = k;
        end
        chk("init_strobe_lat", 64'(got), 64'd1);
        @(negedge clk); #1;
        chk("init_strobe_once", 64'(mem_read), 64'd0);
        wait_acks("a_ack", 1, 40);
        chk("a_strobes", 64'(nstrobe), 64'd1);

        // Read with a 12-cycle busy window, after preloading the word
        q1.push_back(mk_op(1'b1, ADDR_W'(32'h124), 16'hBEEF, 1'b0));
        wait_acks("b_wr_ack", 2, 40);
        ctl_len = 12;
        q0.push_back(mk_op(1'b0, ADDR_W'(32'h124), 16'h0, 1'b0));
        wait_acks("b_rd_ack", 3, 60);
        chk("b_rdata", 64'(rdata), 64'hBEEF);
        chk("b_addr_held", 64'(mem_addr), 64'h124);
        chk("b_p0_acks", 64'(nack0), 64'd2);

        // Byte write from port 1
        ctl_len = 3;
        q1.push_back(mk_op(1'b1, ADDR_W'(32'h3), 16'hA55A, 1'b1));
        got = 0;
        for (int k = 0; k < 20 && got == 0; k++) begin
            @(negedge clk); #1;
            if (mem_read || mem_write) got = 1;
        end
        chk("c_strobe_seen", 64'(got), 64'd1);
        chk("c_write", 64'(mem_write), 64'd1);
        chk("c_read", 64'(mem_read), 64'd0);
        chk("c_byte", 64'(mem_byte), 64'd1);
        chk("c_din", 64'(mem_din), 64'hA55A);
        @(negedge clk); #1;
        chk("c_write_once", 64'(mem_write), 64'd0);
        wait_acks("c_ack", 4, 40);
        chk("c_rdata_kept", 64'(rdata), 64'hBEEF);
        chk("c_p1_acks", 64'(nack1), 64'd2);

        // Contention: both ports request back-to-back, grants must alternate starting at port 0
        order.delete();
        q0.push_back(mk_op(1'b0, ADDR_W'($urandom), 16'h0, 1'b0));
        q0.push_back(mk_op(1'b0, ADDR_W'($urandom), 16'h0, 1'b0));
        q1.push_back(mk_op(1'b0, ADDR_W'($urandom), 16'h0, 1'b0));
        q1.push_back(mk_op(1'b0, ADDR_W'($urandom), 16'h0, 1'b0));
        wait_acks("d_acks", 8, 200);
        chk("d_order_len", 64'(order.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < order.size()) chk("d_order", 64'(order[i]), 64'(i % 2));
        end

        // Late busy: busy rises four cycles after the strobe edge
        base = nstrobe;
        ctl_delay = 3;
        q0.push_back(mk_op(1'b0, ADDR_W'(32'h124), 16'h0, 1'b0));
        wait_acks("f_ack", 9, 60);
        chk("f_strobes", 64'(nstrobe - base), 64'd1);
        chk("f_rdata", 64'(rdata), 64'hBEEF);
        ctl_delay = 0;

        // Reset in WAIT_DONE: outputs cleared, no ack, then a new port-1 request is served
        ctl_len = 10;
        q1.push_back(mk_op(1'b0, ADDR_W'(32'h3), 16'h0, 1'b0));
        got = 0;
        for (int k = 0; k < 30 && got == 0; k++) begin
            @(negedge clk); #1;
            if (mem_busy) got = 1;
        end
        chk("e_busy_seen", 64'(got), 64'd1);
        repeat (2) begin @(negedge clk); #1; end
        reset = 1'b1;
        @(negedge clk); #1;
        chk_reset_outs("e_rst");
        reset = 1'b0;
        base = nack0 + nack1;
        repeat (15) begin @(negedge clk); #1; end
        chk("e_no_ack", 64'(nack0 + nack1), 64'(base));
        ctl_len = 3;
        q1.push_back(mk_op(1'b0, ADDR_W'(32'h124), 16'h0, 1'b0));
        wait_acks("e_new_ack", base + 1, 60);
        chk("e_new_rdata", 64'(rdata), 64'hBEEF);

        // Random traffic on both ports with varying controller timing
        base = nack0 + nack1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            ctl_delay = $urandom_range(0, 3);
            ctl_len   = $urandom_range(1, 6);
            if ($urandom_range(0, 1) == 1) q0.push_back(rand_op());
            else q1.push_back(rand_op());
            n++;
            repeat ($urandom_range(0, 8)) begin @(negedge clk); #1; end
        end
        wait_acks("rand_done", base + n, 3000);
        chk("queues_empty", 64'(q0.size() + q1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
